// File: rtl/instr_assembler.sv
// Packs a host byte stream into big-endian 32-bit instruction words and buffers
// them in a small FIFO presented on the instr_ready / instr_ack / instr_in handshake.
module instr_assembler #(
    parameter int DEPTH_LOG2     = 2,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  instr_ready,
    input  logic                  instr_ack,
    output logic [31:0]           instr_in,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  frame_error,
    input  logic                  err_clear
);

    localparam int                  DEPTH  = 1 << DEPTH_LOG2;
    localparam int                  TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]       T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DEPTH_LOG2:0] FULL   = (DEPTH_LOG2+1)'(DEPTH);

    logic [1:0]            byte_cnt;
    logic [23:0]           partial;
    logic [TW-1:0]         tmo_cnt;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [31:0]           mem [DEPTH];

    logic word_done;
    logic pop;
    logic full;
    logic push;
    logic drop;

    always_comb begin
        word_done = rx_valid && (byte_cnt == 2'd3);
        pop       = instr_ack && (count != '0);
        full      = (count == FULL);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = word_done && (!full || pop);
        drop      = word_done && full && !pop;
    end

    assign instr_ready = (count != '0);
    assign instr_in    = (count != '0) ? mem[rd_ptr] : 32'd0;
    assign fifo_count  = count;

    // Byte packing and inter-byte timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= 2'd0;
            partial     <= 24'd0;
            tmo_cnt     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (rx_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                tmo_cnt  <= '0;
                case (byte_cnt)
                    2'd0:    partial[23:16] <= rx_data;
                    2'd1:    partial[15:8]  <= rx_data;
                    2'd2:    partial[7:0]   <= rx_data;
                    default: ;
                endcase
            end else if (byte_cnt != 2'd0) begin
                if (tmo_cnt == T_LAST) begin
                    byte_cnt    <= 2'd0;
                    tmo_cnt     <= '0;
                    frame_error <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {partial, rx_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: ;
            endcase
        end
    end

    // Clear first so a drop in the same cycle leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (err_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed scenarios plus randomized traffic, all
// checked each cycle against a queue-based model of the byte-to-word FIFO.
module tb_instr_assembler;

    localparam int DL2     = 2;
    localparam int DEPTH   = 1 << DL2;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          instr_ack = 1'b0;
    logic          err_clear = 1'b0;
    logic          instr_ready;
    logic [31:0]   instr_in;
    logic [DL2:0]  fifo_count;
    logic          overflow;
    logic          frame_error;

    instr_assembler #(.DEPTH_LOG2(DL2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .instr_ready(instr_ready), .instr_ack(instr_ack), .instr_in(instr_in),
        .fifo_count(fifo_count), .overflow(overflow), .frame_error(frame_error),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int ferr_pulses = 0;
    bit cmp_en = 1'b1;

    // Behavioural model: words held, bytes of the word in progress, idle cycles since last byte.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_part[$];
    int          m_idle = 0;
    logic        m_ovf = 1'b0;
    logic        m_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic [31:0] w;
        if (reset) begin
            m_fifo.delete();
            m_part.delete();
            m_idle = 0;
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            m_ferr = 1'b0;
            if (instr_ack && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (err_clear) m_ovf = 1'b0;
            if (rx_valid) begin
                m_part.push_back(rx_data);
                m_idle = 0;
                if (m_part.size() == 4) begin
                    w = {m_part[0], m_part[1], m_part[2], m_part[3]};
                    m_part.delete();
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
                    else m_ovf = 1'b1;
                end
            end else if (m_part.size() != 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_part.delete();
                    m_idle = 0;
                    m_ferr = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cmp_en) begin
                check("ready", instr_ready, m_fifo.size() != 0);
                check("count", fifo_count, 32'(m_fifo.size()));
                check("overflow", overflow, m_ovf);
                check("frame_error", frame_error, m_ferr);
                if (m_fifo.size() != 0) check("head", instr_in, m_fifo[0]);
                if (frame_error) ferr_pulses++;
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic a, input logic c);
        @(negedge clk);
        rx_valid  = v;
        rx_data   = d;
        instr_ack = a;
        err_clear = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic send_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, w[31-8*i -: 8], 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_bytes(w, 4);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        check(name, instr_in, exp);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    initial begin
        int base;
        int dens;
        logic v;

        // Reset state
        @(negedge clk);
        #2;
        check("rst_ready", instr_ready, 0);
        check("rst_instr", instr_in, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_error, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single word, one-cycle latency, ack empties the FIFO
        send_word(32'h12345678);
        #2;
        check("t1_ready", instr_ready, 1);
        check("t1_instr", instr_in, 32'h12345678);
        check("t1_count", fifo_count, 1);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        check("t1_ack_ready", instr_ready, 0);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) send_word(32'hA0000000 + 32'(i));
        #2;
        check("t2_count", fifo_count, 4);
        check("t2_ovf", overflow, 1);
        for (int i = 1; i <= 4; i++) pop_check("t2_pop", 32'hA0000000 + 32'(i));
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        check("t2_clear", overflow, 0);
        check("t2_empty", fifo_count, 0);

        // Full plus simultaneous ack on the completing byte
        for (int i = 1; i <= 4; i++) send_word(32'hB0000000 + 32'(i));
        send_bytes(32'hB0000005, 3);
        drive(1'b1, 8'h05, 1'b1, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        check("t3_count", fifo_count, 4);
        check("t3_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) pop_check("t3_pop", 32'hB0000000 + 32'(i));
        idle(1);

        // Timeout discards the partial word
        base = ferr_pulses;
        send_bytes(32'hDEAD0000, 2);
        idle(20);
        #2;
        check("t4_pulses", ferr_pulses - base, 1);
        check("t4_nopush", fifo_count, 0);
        send_word(32'h11223344);
        #2;
        check("t4_instr", instr_in, 32'h11223344);
        pop_check("t4_pop", 32'h11223344);

        // Gap of TIMEOUT-1 idle cycles survives, gap of TIMEOUT expires
        base = ferr_pulses;
        send_bytes(32'h01020304, 1);
        idle(TIMEOUT - 1);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        drive(1'b1, 8'h04, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        check("t5_noerr", ferr_pulses - base, 0);
        check("t5_word", instr_in, 32'h01020304);
        pop_check("t5_pop", 32'h01020304);
        send_bytes(32'h55000000, 1);
        idle(TIMEOUT + 2);
        #2;
        check("t5_err", ferr_pulses - base, 1);
        check("t5_nopush", fifo_count, 0);

        // Reset mid-word, then spurious ack while empty
        send_bytes(32'h99880000, 2);
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        send_word(32'hCAFEBABE);
        #2;
        check("t6_instr", instr_in, 32'hCAFEBABE);
        pop_check("t6_pop", 32'hCAFEBABE);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        check("t6_empty_ack", fifo_count, 0);

        // Randomized traffic in bursts of differing byte density
        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(0, 2);
            for (int c = 0; c < 200; c++) begin
                if (dens == 0) v = ($urandom_range(0, 1) == 1);
                else if (dens == 1) v = ($urandom_range(0, 7) == 0);
                else v = ($urandom_range(0, 24) == 0);
                drive(v, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
            end
        end
        idle(4);
        #2;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
